// File: rtl/ex_alu_unit_pkg.sv
// Shared encodings for the EX-stage ALU: ALU operation codes, main-control
// ALUOp classes and R-type funct values.
package ex_alu_unit_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_NOR = 3'b100,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic [2:0] ALUOP_MEM   = 3'b000;
    localparam logic [2:0] ALUOP_BEQ   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_ANDI  = 3'b011;
    localparam logic [2:0] ALUOP_ORI   = 3'b100;
    localparam logic [2:0] ALUOP_SLTI  = 3'b101;
    localparam logic [2:0] ALUOP_ADDI  = 3'b110;
    localparam logic [2:0] ALUOP_RSVD  = 3'b111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/ex_alu_unit_if.sv
// Operand, control and result bundle between the EX stage and the ALU unit.
interface ex_alu_unit_if;

    logic        en;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc_plus4;
    logic [31:0] imm;
    logic [2:0]  op;
    logic [31:0] result_q;
    logic        zero_q;
    logic [31:0] br_target_q;
    logic        br_of_q;

    modport master (
        output en, alu_op, funct, a, b, pc_plus4, imm,
        input  op, result_q, zero_q, br_target_q, br_of_q
    );

    modport slave (
        input  en, alu_op, funct, a, b, pc_plus4, imm,
        output op, result_q, zero_q, br_target_q, br_of_q
    );

endinterface

// File: rtl/ex_alu_unit_add32.sv
// 32-bit adder with carry-out, used for the branch-target computation.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage ALU: ALU-control decode, 32-bit datapath and branch-target adder,
// all captured in one enable-gated output register.
module ex_alu_unit
    import ex_alu_unit_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    ex_alu_unit_if.slave bus
);

    alu_op_e     op;
    logic [31:0] result_d;
    logic        zero_d;
    logic [31:0] br_target_d;
    logic        br_of_d;
    logic [31:0] imm_sh;

    logic [31:0] result_q;
    logic        zero_q;
    logic [31:0] br_target_q;
    logic        br_of_q;

    // NOTE: assign a default before the case so every path drives op and no latch is inferred.
    always_comb begin
        op = ALU_ADD;
        case (bus.alu_op)
            ALUOP_MEM:   op = ALU_ADD;
            ALUOP_BEQ:   op = ALU_SUB;
            ALUOP_ANDI:  op = ALU_AND;
            ALUOP_ORI:   op = ALU_OR;
            ALUOP_SLTI:  op = ALU_SLT;
            ALUOP_ADDI:  op = ALU_ADD;
            ALUOP_RSVD:  op = ALU_ADD;
            ALUOP_RTYPE: begin
                case (bus.funct)
                    FUNCT_ADD: op = ALU_ADD;
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_NOR: op = ALU_NOR;
                    FUNCT_SLT: op = ALU_SLT;
                    default:   op = ALU_ADD;
                endcase
            end
            default:     op = ALU_ADD;
        endcase
    end

    assign bus.op = op;

    // Signed compare rather than the sign of a-b, so overflow cannot flip SLT.
    always_comb begin
        result_d = bus.a + bus.b;
        case (op)
            ALU_AND: result_d = bus.a & bus.b;
            ALU_OR:  result_d = bus.a | bus.b;
            ALU_NOR: result_d = ~(bus.a | bus.b);
            ALU_SUB: result_d = bus.a - bus.b;
            ALU_SLT: result_d = ($signed(bus.a) < $signed(bus.b)) ? 32'd1 : 32'd0;
            default: result_d = bus.a + bus.b;
        endcase
        zero_d = (result_d == 32'h0);
    end

    assign imm_sh = bus.imm << 2;

    add32 u_br_add (
        .a    (bus.pc_plus4),
        .b    (imm_sh),
        .sum  (br_target_d),
        .cout (br_of_d)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= 32'h0;
            zero_q      <= 1'b0;
            br_target_q <= 32'h0;
            br_of_q     <= 1'b0;
        end else if (bus.en) begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            br_target_q <= br_target_d;
            br_of_q     <= br_of_d;
        end
    end

    assign bus.result_q    = result_q;
    assign bus.zero_q      = zero_q;
    assign bus.br_target_q = br_target_q;
    assign bus.br_of_q     = br_of_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed cases plus randomized traffic
// compared against a behavioural reference model.
module tb_ex_alu_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] exp_result;
    logic        exp_zero;
    logic [31:0] exp_bt;
    logic        exp_of;

    ex_alu_unit_if bus ();

    ex_alu_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] ref_op(input logic [2:0] ao, input logic [5:0] fn);
        case (ao)
            3'd0: return 3'b010;
            3'd1: return 3'b110;
            3'd3: return 3'b000;
            3'd4: return 3'b001;
            3'd5: return 3'b111;
            3'd2: begin
                case (fn)
                    6'd32:   return 3'b010;
                    6'd34:   return 3'b110;
                    6'd36:   return 3'b000;
                    6'd37:   return 3'b001;
                    6'd39:   return 3'b100;
                    6'd42:   return 3'b111;
                    default: return 3'b010;
                endcase
            end
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (opc)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b100:  return ~(x | y);
            3'b110:  return 32'((longint'(x) - longint'(y)) & 64'hFFFF_FFFF);
            3'b111:  return (sx < sy) ? 32'd1 : 32'd0;
            default: return 32'((longint'(x) + longint'(y)) & 64'hFFFF_FFFF);
        endcase
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_result"}, bus.result_q, exp_result);
        check({tag, "_zero"}, 32'(bus.zero_q), 32'(exp_zero));
        check({tag, "_bt"}, bus.br_target_q, exp_bt);
        check({tag, "_of"}, 32'(bus.br_of_q), 32'(exp_of));
    endtask

    // Called just after a falling edge: drive, check op, clock once, check registers.
    task automatic step(input string tag, input logic [2:0] ao, input logic [5:0] fn,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] pc, input logic [31:0] im, input logic e);
        longint tsum;
        bus.alu_op   = ao;
        bus.funct    = fn;
        bus.a        = av;
        bus.b        = bv;
        bus.pc_plus4 = pc;
        bus.imm      = im;
        bus.en       = e;
        #1;
        check({tag, "_op"}, 32'(bus.op), 32'(ref_op(ao, fn)));
        @(posedge clk);
        if (e) begin
            exp_result = ref_alu(ref_op(ao, fn), av, bv);
            exp_zero   = (exp_result == 32'd0);
            tsum       = longint'(pc) + (longint'(im) * 4 % 64'h1_0000_0000);
            exp_bt     = 32'(tsum % 64'h1_0000_0000);
            exp_of     = (tsum >= 64'h1_0000_0000);
        end
        @(negedge clk);
        check_regs(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_result = '0;
        exp_zero   = 1'b0;
        exp_bt     = '0;
        exp_of     = 1'b0;

        // Reset with unknown inputs and en high
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.alu_op   = 'x;
        bus.funct    = 'x;
        bus.a        = 'x;
        bus.b        = 'x;
        bus.pc_plus4 = 'x;
        bus.imm      = 'x;
        #1;
        check_regs("reset_immediate");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_regs("reset_x_inputs");
        rst_n = 1'b1;

        step("add_7_5", 3'b010, 6'b100000, 32'd7, 32'd5, 32'h100, 32'd4, 1'b1);
        check("add_7_5_const", bus.result_q, 32'd12);
        check("add_7_5_zero_const", 32'(bus.zero_q), 32'd0);

        step("beq_equal", 3'b001, 6'h00, 32'h1234, 32'h1234, 32'h0, 32'h0, 1'b1);
        check("beq_op_const", 32'(bus.op), 32'b110);
        check("beq_zero_const", 32'(bus.zero_q), 32'd1);

        step("slt_neg1_1", 3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b1);
        check("slt_neg1_1_const", bus.result_q, 32'd1);
        step("slt_1_neg1", 3'b010, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
        check("slt_1_neg1_const", bus.result_q, 32'd0);
        step("slt_overflow", 3'b101, 6'h00, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1);
        check("slt_overflow_const", bus.result_q, 32'd1);

        step("br_wrap", 3'b000, 6'h00, 32'd1, 32'd2, 32'h0000_0008, 32'hFFFF_FFFE, 1'b1);
        check("br_wrap_bt_const", bus.br_target_q, 32'h0000_0000);
        check("br_wrap_of_const", 32'(bus.br_of_q), 32'd1);

        step("funct_unlisted", 3'b010, 6'b000000, 32'd3, 32'd4, 32'h40, 32'h10, 1'b1);
        check("funct_unlisted_op_const", 32'(bus.op), 32'b010);
        check("funct_unlisted_const", bus.result_q, 32'd7);

        step("nor_op", 3'b010, 6'b100111, 32'h0F0F_0000, 32'h0000_00FF, 32'h0, 32'h1, 1'b1);
        check("nor_const", bus.result_q, 32'hF0F0_FF00);

        // Hold with en low while inputs change
        step("load_12", 3'b010, 6'b100000, 32'd7, 32'd5, 32'h200, 32'h3, 1'b1);
        step("hold_1", 3'b011, 6'h00, 32'hFFFF, 32'h1, 32'h1, 32'h1, 1'b0);
        step("hold_2", 3'b001, 6'h00, 32'h5, 32'h5, 32'h2, 32'h2, 1'b0);
        step("hold_3", 3'b100, 6'h00, 32'hA, 32'h5, 32'h3, 32'h3, 1'b0);
        check("hold_const", bus.result_q, 32'd12);

        // Mid-operation reset pulse between edges, with en high
        bus.en = 1'b1;
        rst_n  = 1'b0;
        #1;
        exp_result = '0;
        exp_zero   = 1'b0;
        exp_bt     = '0;
        exp_of     = 1'b0;
        check_regs("reset_pulse_immediate");
        @(posedge clk);
        @(negedge clk);
        check_regs("reset_overrides_en");
        rst_n = 1'b1;
        step("first_after_reset", 3'b110, 6'h00, 32'd100, 32'hFFFF_FFFF, 32'h1000, 32'hFFFF_FFFF, 1'b1);
        check("first_after_reset_const", bus.result_q, 32'd99);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  fn;
            logic [31:0] av;
            logic [31:0] bv;
            logic [5:0]  fn_list [6];
            fn_list = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 5)];
            av = $urandom;
            bv = ($urandom_range(0, 3) == 0) ? av : 32'($urandom);
            step("rand", 3'($urandom), fn, av, bv, $urandom, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_alu_unit.md
EX_ALU_UNIT -- requirements
Module: ex_alu_unit

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 en  in  1  capture enable for the output register; when low, registered outputs hold.
REQ-005 alu_op  in  3  ALUOp class from main control.
REQ-006 funct  in  6  R-type function field (instruction bits 5:0).
REQ-007 a  in  32  ALU operand 1 (after forwarding).
REQ-008 b  in  32  ALU operand 2 (after ALUSrc/forwarding).
REQ-009 pc_plus4  in  32  PC+4 of the instruction in EX.
REQ-010 imm  in  32  sign-extended immediate.
REQ-011 op  out  3  decoded ALU operation, combinational.
REQ-012 result_q  out  32  registered ALU result.
REQ-013 zero_q  out  1  registered zero flag.
REQ-014 br_target_q  out  32  registered branch target.
REQ-015 br_of_q  out  1  registered carry-out of the branch-target add.

Function
REQ-016 ALU op codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111, NOR=100; codes 011/101 behave as ADD.
REQ-017 Decode alu_op to op: 000->ADD (load/store); 001->SUB (beq); 010->decode funct; 011->AND (andi); 100->OR (ori); 101->SLT (slti); 110->ADD (addi); 111->ADD.
REQ-018 Decode funct to op: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 100111->NOR, 101010->SLT; any other funct->ADD.
REQ-019 op is purely combinational from alu_op and funct, with no clock dependence.
REQ-020 ADD/SUB are modulo 2^32 (a+b, a-b); overflow is ignored and causes no trap.
REQ-021 SLT yields 32'd1 when a<b as signed two's complement, else 32'd0; the compare is correct even when a-b overflows.
REQ-022 AND/OR/NOR are bitwise on 32 bits.
REQ-023 Zero flag = (ALU result == 32'h0), computed on the current op's result.
REQ-024 Branch target = pc_plus4 + (imm << 2), modulo 2^32; br_of = carry-out of bit 31.
REQ-025 On a clk rising edge with en=1, result_q/zero_q/br_target_q/br_of_q load the combinational values; latency is 1 cycle.
REQ-026 With en=0, all registered outputs hold their value.
REQ-027 Inputs of X never reach registered outputs during reset.

Reset
REQ-028 While rst_n=0, result_q=0, zero_q=0, br_target_q=0 and br_of_q=0 immediately, without waiting for a clock edge.
REQ-029 Reset applied mid-operation overrides en, and the first capture after release occurs on the first rising edge with rst_n=1 and en=1.

Structure
REQ-030 A shared package holds the ALU op codes (REQ-016), the ALUOp class codes (REQ-017) and the funct codes (REQ-018).
REQ-031 add32 is the single sub-module: a 32-bit adder with sum and carry-out outputs, instantiated once for the branch target; the ALU add/sub may reuse it or be inline.
REQ-032 ALU-control decode and ALU datapath are separate combinational blocks feeding one always_ff output register.

Verification
REQ-033 alu_op=010, funct=100000, a=7, b=5, en=1 -> op=010, and after 1 edge result_q=12, zero_q=0.
REQ-034 alu_op=001, a=b=32'h1234 -> op=110, and after 1 edge result_q=0, zero_q=1.
REQ-035 alu_op=010, funct=101010, a=32'hFFFFFFFF, b=1 -> result_q=1; swapped operands -> result_q=0.
REQ-036 pc_plus4=32'h00000008, imm=32'hFFFFFFFE -> br_target_q=32'h00000000, br_of_q=1.
REQ-037 Load result_q=12, drop en, change inputs for 3 edges -> result_q stays 12; pulse rst_n low between edges -> all outputs 0 at once.
REQ-038 Unlisted funct 000000 with alu_op=010 and a=3, b=4 -> op=010, result_q=7.
